csr_access_ctrl: RTL and testbench

- Sequencer between the execute stage and the CSR register file.
- Accepts one CSR instruction at a time (csrrd / csrwr / csrxchg) over a valid/ready handshake.
- Drives the register file's read port, then its masked write port, and returns the old CSR value with its destination tag.
- Exception/ertn commit (flush) has absolute priority: it aborts any in-flight access and suppresses its write.

---
 rtl/csr_access_ctrl_if.sv | 33 +++
 rtl/csr_access_ctrl.sv | 125 ++++++++++++
 tb/tb_csr_access_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_access_ctrl_if.sv
// Request/response channel between the execute stage and the CSR access controller.
interface csr_access_ctrl_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5
) ();

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_mask;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;

  // Execute/writeback side.
  modport master (
    output req_valid, req_op, req_addr, req_mask, req_wdata, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_addr, req_mask, req_wdata, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );

endinterface

// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: read old value, optionally masked-write, return old value with tag.
// A flush aborts any in-flight access, suppresses its write and its response.
module csr_access_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  csr_access_ctrl_if.slave  bus,
  input  logic              flush,
  output logic              csr_re,
  output logic [ADDR_W-1:0] csr_raddr,
  input  logic [DATA_W-1:0] csr_rdata,
  output logic              csr_we,
  output logic [ADDR_W-1:0] csr_waddr,
  output logic [DATA_W-1:0] csr_wmask,
  output logic [DATA_W-1:0] csr_wdata,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [1:0] OpRd   = 2'b00;
  localparam logic [1:0] OpWr   = 2'b01;
  localparam logic [1:0] OpXchg = 2'b10;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  // State and latched-request registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      op_q       <= OpRd;
      addr_q     <= '0;
      mask_q     <= '0;
      wdata_q    <= '0;
      tag_q      <= '0;
      data_q     <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      mask_q     <= mask_d;
      wdata_q    <= wdata_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Next-state and output decode; flush overrides every transition.
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    mask_d         = mask_q;
    wdata_d        = wdata_q;
    tag_d          = tag_q;
    data_d         = data_q;
    wr_count_d     = wr_count_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data  = '0;
    bus.resp_tag   = '0;
    csr_re         = 1'b0;
    csr_raddr      = '0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wmask      = '0;
    csr_wdata      = '0;

    unique case (state_q)
      StIdle: begin
        bus.req_ready = !flush;
        if (bus.req_valid && !flush) begin
          // Reserved op 11 behaves as a plain read.
          op_d    = (bus.req_op == 2'b11) ? OpRd : bus.req_op;
          addr_d  = bus.req_addr;
          mask_d  = bus.req_mask;
          wdata_d = bus.req_wdata;
          tag_d   = bus.req_tag;
          state_d = StRead;
        end
      end
      StRead: begin
        csr_re    = 1'b1;
        csr_raddr = addr_q;
        data_d    = csr_rdata;
        state_d   = (op_q == OpRd) ? StResp : StWrite;
      end
      StWrite: begin
        csr_we    = !flush;
        csr_waddr = addr_q;
        csr_wdata = wdata_q;
        csr_wmask = (op_q == OpXchg) ? mask_q : '1;
        if (!flush) wr_count_d = wr_count_q + 1'b1;
        state_d = StResp;
      end
      StResp: begin
        bus.resp_valid = !flush;
        bus.resp_data  = data_q;
        bus.resp_tag   = tag_q;
        if (bus.resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) state_d = StIdle;
  end

  assign busy     = (state_q != StIdle);
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Self-checking bench for csr_access_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level model of the CSR file. A second instance with a
// 4-bit counter shares the same stimulus so counter wrap is reachable quickly.
module tb_csr_access_ctrl;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TAG_W  = 5;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        csr_re, csr_we, busy;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wmask, csr_wdata;
  logic [15:0] wr_count;

  logic        csr_re_s, csr_we_s, busy_s;
  logic [13:0] csr_raddr_s, csr_waddr_s;
  logic [31:0] csr_rdata_s, csr_wmask_s, csr_wdata_s;
  logic [3:0]  wr_count_s;

  logic [31:0] rf [64];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr   = 0;

  csr_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();
  csr_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus_s ();

  assign bus_s.req_valid  = bus.req_valid;
  assign bus_s.req_op     = bus.req_op;
  assign bus_s.req_addr   = bus.req_addr;
  assign bus_s.req_mask   = bus.req_mask;
  assign bus_s.req_wdata  = bus.req_wdata;
  assign bus_s.req_tag    = bus.req_tag;
  assign bus_s.resp_ready = bus.resp_ready;

  assign csr_rdata   = rf[csr_raddr[5:0]];
  assign csr_rdata_s = rf[csr_raddr_s[5:0]];

  csr_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(16)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .flush     (flush),
    .csr_re    (csr_re),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .csr_we    (csr_we),
    .csr_waddr (csr_waddr),
    .csr_wmask (csr_wmask),
    .csr_wdata (csr_wdata),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  csr_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(4)) dut_s (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus_s),
    .flush     (flush),
    .csr_re    (csr_re_s),
    .csr_raddr (csr_raddr_s),
    .csr_rdata (csr_rdata_s),
    .csr_we    (csr_we_s),
    .csr_waddr (csr_waddr_s),
    .csr_wmask (csr_wmask_s),
    .csr_wdata (csr_wdata_s),
    .busy      (busy_s),
    .wr_count  (wr_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // End the current cycle: apply any write the DUT presents to the CSR file, then move to
  // the next negedge where outputs are sampled and inputs are driven.
  task automatic cyc();
    #1;
    if (csr_we) begin
      rf[csr_waddr[5:0]] = (rf[csr_waddr[5:0]] & ~csr_wmask) | (csr_wdata & csr_wmask);
    end
    @(negedge clk);
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [13:0] a, input logic [31:0] m,
                           input logic [31:0] w, input logic [4:0] t);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = a;
    bus.req_mask  = m;
    bus.req_wdata = w;
    bus.req_tag   = t;
  endtask

  // Drop valid and garble the request fields; latched values must be unaffected.
  task automatic scramble();
    bus.req_valid = 1'b0;
    bus.req_op    = 2'($urandom);
    bus.req_addr  = 14'($urandom);
    bus.req_mask  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_tag   = 5'($urandom);
  endtask

  // Plain csrwr to a random address with immediate response acceptance.
  task automatic run_wr();
    bus.resp_ready = 1'b1;
    drive_req(2'b01, 14'($urandom_range(0, 63)), 32'h0, $urandom, 5'd0);
    cyc();
    scramble();
    cyc();
    cyc();
    cyc();
    exp_wr++;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    flush = 1'b0;
    scramble();
    bus.resp_ready = 1'b0;
    cyc();
    cyc();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", bus.resp_valid); end
    n_checks++; if ({csr_re, csr_we} !== 2'b00) begin n_fail++; $display("FAIL reset_re_we: got %b want 00", {csr_re, csr_we}); end
    n_checks++; if ({csr_raddr, csr_waddr, csr_wmask, csr_wdata} !== '0) begin n_fail++; $display("FAIL reset_csr_bus: got %h want 0", {csr_raddr, csr_waddr, csr_wmask, csr_wdata}); end
    n_checks++; if ({bus.resp_data, bus.resp_tag} !== '0) begin n_fail++; $display("FAIL reset_resp_fields: got %h want 0", {bus.resp_data, bus.resp_tag}); end
    n_checks++; if (wr_count !== 16'h0) begin n_fail++; $display("FAIL reset_wr_count: got %h want 0", wr_count); end
    flush = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_flush_ready: got %b want 0", bus.req_ready); end
    flush = 1'b0;
    rstn = 1'b1;
    cyc();
    exp_wr = 0;
  endtask

  task automatic test_csrrd();
    rf[5] = 32'h0000_0800;
    bus.resp_ready = 1'b1;
    drive_req(2'b00, 14'h005, $urandom, $urandom, 5'd3);
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_accept: got %b want 1", bus.req_ready); end
    cyc();
    scramble();
    #1;
    n_checks++; if (csr_re !== 1'b1 || csr_raddr !== 14'h005) begin n_fail++; $display("FAIL rd_read_port: got re=%b addr=%h want re=1 addr=005", csr_re, csr_raddr); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early_resp: got %b want 0", bus.resp_valid); end
    cyc();
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h0000_0800 || bus.resp_tag !== 5'd3) begin n_fail++; $display("FAIL rd_resp: got v=%b d=%h t=%0d want v=1 d=00000800 t=3", bus.resp_valid, bus.resp_data, bus.resp_tag); end
    n_checks++; if (csr_we !== 1'b0) begin n_fail++; $display("FAIL rd_no_write: got %b want 0", csr_we); end
    cyc();
    n_checks++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_done: got busy=%b rv=%b want 0 0", busy, bus.resp_valid); end
  endtask

  task automatic test_csrwr();
    rf[48] = 32'h1234_5678;
    bus.resp_ready = 1'b1;
    drive_req(2'b01, 14'h030, $urandom, 32'hDEAD_BEEF, 5'd9);
    cyc();
    scramble();
    cyc();
    n_checks++; if (csr_we !== 1'b1 || csr_wmask !== 32'hFFFF_FFFF || csr_waddr !== 14'h030 || csr_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_write_port: got we=%b m=%h a=%h d=%h want 1 ffffffff 030 deadbeef", csr_we, csr_wmask, csr_waddr, csr_wdata); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_early_resp: got %b want 0", bus.resp_valid); end
    cyc();
    exp_wr++;
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h1234_5678 || bus.resp_tag !== 5'd9) begin n_fail++; $display("FAIL wr_resp: got v=%b d=%h t=%0d want v=1 d=12345678 t=9", bus.resp_valid, bus.resp_data, bus.resp_tag); end
    n_checks++; if (wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL wr_count: got %0d want %0d", wr_count, exp_wr); end
    cyc();
    n_checks++; if (rf[48] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rf_value: got %h want deadbeef", rf[48]); end
  endtask

  task automatic test_csrxchg();
    rf[0] = 32'hA5A5_A5A8;
    bus.resp_ready = 1'b1;
    drive_req(2'b10, 14'h000, 32'h0000_0007, 32'h0000_0004, 5'd1);
    cyc();
    scramble();
    cyc();
    n_checks++; if (csr_we !== 1'b1 || csr_wmask !== 32'h0000_0007 || csr_wdata !== 32'h0000_0004 || csr_waddr !== 14'h000) begin n_fail++; $display("FAIL xchg_write_port: got we=%b m=%h d=%h a=%h want 1 00000007 00000004 000", csr_we, csr_wmask, csr_wdata, csr_waddr); end
    cyc();
    exp_wr++;
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hA5A5_A5A8 || bus.resp_tag !== 5'd1) begin n_fail++; $display("FAIL xchg_resp: got v=%b d=%h t=%0d want 1 a5a5a5a8 1", bus.resp_valid, bus.resp_data, bus.resp_tag); end
    cyc();
    n_checks++; if (rf[0] !== 32'hA5A5_A5AC) begin n_fail++; $display("FAIL xchg_rf_value: got %h want a5a5a5ac", rf[0]); end
    n_checks++; if (wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL xchg_count: got %0d want %0d", wr_count, exp_wr); end
  endtask

  task automatic test_flush();
    rf[7] = 32'h1111_1111;
    bus.resp_ready = 1'b1;
    drive_req(2'b01, 14'h007, 32'h0, 32'h2222_2222, 5'd4);
    cyc();
    scramble();
    cyc();
    flush = 1'b1;
    #1;
    n_checks++; if (csr_we !== 1'b0) begin n_fail++; $display("FAIL flush_we: got %b want 0", csr_we); end
    cyc();
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_idle: got busy=%b rv=%b want 0 0", busy, bus.resp_valid); end
    cyc();
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_resp: got %b want 0", bus.resp_valid); end
    n_checks++; if (wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL flush_count: got %0d want %0d", wr_count, exp_wr); end
    n_checks++; if (rf[7] !== 32'h1111_1111) begin n_fail++; $display("FAIL flush_rf: got %h want 11111111", rf[7]); end
    // Flush coinciding with a request in idle blocks acceptance.
    flush = 1'b1;
    drive_req(2'b00, 14'h001, 32'h0, 32'h0, 5'd0);
    #1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_block_ready: got %b want 0", bus.req_ready); end
    cyc();
    flush = 1'b0;
    scramble();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_block_accept: got busy=%b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    rf[9]  = 32'hCAFE_F00D;
    rf[10] = 32'h0BAD_CAFE;
    bus.resp_ready = 1'b0;
    drive_req(2'b00, 14'h009, 32'h0, 32'h0, 5'd6);
    cyc();
    scramble();
    cyc();
    for (int i = 0; i < 5; i++) begin
      drive_req(2'b00, 14'h00A, 32'h0, 32'h0, 5'd7);
      #1;
      n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'hCAFE_F00D || bus.resp_tag !== 5'd6) begin n_fail++; $display("FAIL stall_resp[%0d]: got v=%b d=%h t=%0d want 1 cafef00d 6", i, bus.resp_valid, bus.resp_data, bus.resp_tag); end
      n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
      cyc();
    end
    bus.resp_ready = 1'b1;
    cyc();
    #1;
    n_checks++; if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: got ready=%b busy=%b want 1 0", bus.req_ready, busy); end
    cyc();
    scramble();
    #1;
    n_checks++; if (csr_re !== 1'b1 || csr_raddr !== 14'h00A) begin n_fail++; $display("FAIL b2b_read: got re=%b a=%h want 1 00a", csr_re, csr_raddr); end
    cyc();
    n_checks++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'h0BAD_CAFE || bus.resp_tag !== 5'd7) begin n_fail++; $display("FAIL b2b_resp: got v=%b d=%h t=%0d want 1 0badcafe 7", bus.resp_valid, bus.resp_data, bus.resp_tag); end
    cyc();
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [13:0] a;
    logic [31:0] m, w, old, newv;
    logic [4:0]  t;
    bit          wr, commit, done, exp_we, exp_rv, exp_re;
    int          er, dly, fk;
    for (int n = 0; n < 200; n++) begin
      op   = 2'($urandom);
      a    = 14'($urandom_range(0, 63));
      m    = $urandom;
      w    = $urandom;
      t    = 5'($urandom);
      wr   = (op == 2'b01) || (op == 2'b10);
      er   = wr ? 3 : 2;
      dly  = $urandom_range(0, 3);
      fk   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, er + dly) : 0;
      old  = rf[a[5:0]];
      newv = (op == 2'b01) ? w : (op == 2'b10) ? ((old & ~m) | (w & m)) : old;
      commit = wr && (fk == 0 || fk > 2);
      drive_req(op, a, m, w, t);
      #1;
      n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_accept[%0d]: got %b want 1", n, bus.req_ready); end
      cyc();
      done = 1'b0;
      for (int k = 1; k <= er + dly && !done; k++) begin
        scramble();
        flush = (k == fk);
        bus.resp_ready = (k >= er + dly);
        #1;
        exp_re = (k == 1);
        exp_we = wr && (k == 2) && (k != fk);
        exp_rv = (k >= er) && (k != fk);
        n_checks++; if (csr_re !== exp_re || csr_we !== exp_we || bus.resp_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_ctrl[%0d.%0d]: got re=%b we=%b rv=%b want %b %b %b", n, k, csr_re, csr_we, bus.resp_valid, exp_re, exp_we, exp_rv); end
        if (exp_rv) begin
          n_checks++; if (bus.resp_data !== old || bus.resp_tag !== t) begin n_fail++; $display("FAIL rnd_resp[%0d]: got d=%h t=%0d want d=%h t=%0d", n, bus.resp_data, bus.resp_tag, old, t); end
        end
        if (exp_we) begin
          n_checks++; if (csr_waddr !== a || csr_wdata !== w || csr_wmask !== ((op == 2'b10) ? m : 32'hFFFF_FFFF)) begin n_fail++; $display("FAIL rnd_wport[%0d]: got a=%h d=%h m=%h want a=%h d=%h op=%0d", n, csr_waddr, csr_wdata, csr_wmask, a, w, op); end
        end
        if (k == fk || (exp_rv && bus.resp_ready)) done = 1'b1;
        cyc();
      end
      flush = 1'b0;
      bus.resp_ready = 1'b0;
      if (commit) exp_wr++;
      n_checks++; if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_end[%0d]: got busy=%b rv=%b want 0 0", n, busy, bus.resp_valid); end
      n_checks++; if (rf[a[5:0]] !== (commit ? newv : old)) begin n_fail++; $display("FAIL rnd_rf[%0d]: got %h want %h", n, rf[a[5:0]], commit ? newv : old); end
      n_checks++; if (wr_count !== 16'(exp_wr) || wr_count_s !== 4'(exp_wr)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d", n, wr_count, wr_count_s, exp_wr); end
    end
  endtask

  task automatic test_wrap();
    while (exp_wr % 16 != 15) run_wr();
    n_checks++; if (wr_count_s !== 4'hF) begin n_fail++; $display("FAIL wrap_pre: got %h want f", wr_count_s); end
    run_wr();
    n_checks++; if (wr_count_s !== 4'h0) begin n_fail++; $display("FAIL wrap_zero: got %h want 0", wr_count_s); end
    n_checks++; if (wr_count !== 16'(exp_wr)) begin n_fail++; $display("FAIL wrap_wide: got %0d want %0d", wr_count, exp_wr); end
  endtask

  task automatic test_midreset();
    bus.resp_ready = 1'b1;
    drive_req(2'b01, 14'h003, 32'h0, $urandom, 5'd2);
    cyc();
    scramble();
    rstn = 1'b0;
    cyc();
    exp_wr = 0;
    n_checks++; if (busy !== 1'b0 || csr_re !== 1'b0 || csr_we !== 1'b0 || bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_outputs: got busy=%b re=%b we=%b rv=%b want 0000", busy, csr_re, csr_we, bus.resp_valid); end
    n_checks++; if (wr_count !== 16'h0 || wr_count_s !== 4'h0) begin n_fail++; $display("FAIL mrst_count: got %h/%h want 0", wr_count, wr_count_s); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready: got %b want 1", bus.req_ready); end
    rstn = 1'b1;
    cyc();
    cyc();
    n_checks++; if (csr_we !== 1'b0 || busy !== 1'b0 || wr_count !== 16'h0) begin n_fail++; $display("FAIL mrst_after: got we=%b busy=%b cnt=%0d want 0 0 0", csr_we, busy, wr_count); end
  endtask

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.req_addr = '0;
    bus.req_mask = '0;
    bus.req_wdata = '0;
    bus.req_tag = '0;
    for (int i = 0; i < 64; i++) rf[i] = $urandom;
    @(negedge clk);
    test_reset();
    test_csrrd();
    test_csrwr();
    test_csrxchg();
    test_flush();
    test_back_to_back();
    test_random();
    test_wrap();
    test_midreset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
